// File: rtl/jtframe_debug_keys_pkg.sv
// Shared types, scan-code constants and key decode helpers for the
// debug-overlay keyboard front-end (PS/2 set-2 scan codes).
package jtframe_debug_keys_pkg;

    // Decoder state: where we are inside a multi-byte scan-code sequence
    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXTBRK,
        PAUSE
    } state_e;

    // Prefix bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;

    // Keyboard-to-host protocol bytes that are never key codes
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    // Mapped keys
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_CTRL     = 8'h14;
    localparam logic [7:0] SC_KP_PLUS  = 8'h79;
    localparam logic [7:0] SC_EQUALS   = 8'h55;
    localparam logic [7:0] SC_KP_MINUS = 8'h7B;
    localparam logic [7:0] SC_DASH     = 8'h4E;
    localparam logic [7:0] SC_F12      = 8'h07;
    localparam logic [7:0] SC_F1       = 8'h05;
    localparam logic [7:0] SC_F2       = 8'h06;
    localparam logic [7:0] SC_F3       = 8'h04;
    localparam logic [7:0] SC_F4       = 8'h0C;

    // Keys 1..8 on the main row
    localparam logic [7:0] DIGIT_CODES [8] = '{
        8'h16, 8'h1E, 8'h26, 8'h25,
        8'h2E, 8'h36, 8'h3D, 8'h3E
    };

    // Bytes still to be swallowed after E1 (Pause is 8 bytes long)
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Bit positions in the internal key-state vector
    localparam int K_LSHIFT   = 0;
    localparam int K_RSHIFT   = 1;
    localparam int K_LCTRL    = 2;
    localparam int K_RCTRL    = 3;
    localparam int K_KP_PLUS  = 4;
    localparam int K_EQUALS   = 5;
    localparam int K_KP_MINUS = 6;
    localparam int K_DASH     = 7;
    localparam int K_F12      = 8;
    localparam int K_F1       = 9;
    localparam int K_F4       = 12;
    localparam int K_D1       = 13;
    localparam int K_D8       = 20;
    localparam int NKEYS      = 21;

    // Protocol bytes that must not be treated as key makes
    function automatic logic is_ignored(input logic [7:0] code);
        is_ignored = (code == SC_BAT)    || (code == SC_ACK)  ||
                     (code == SC_RESEND) || (code == SC_ECHO) ||
                     (code == SC_ERR0)   || (code == SC_ERR1);
    endfunction

    // One-hot (or zero) mask of the key addressed by a code.
    // Extended codes only map right ctrl; E0 12 / E0 59 are the
    // fake shifts emitted around cursor keys and must be dropped.
    function automatic logic [NKEYS-1:0] key_mask(
        input logic [7:0] code,
        input logic       ext
    );
        key_mask = '0;
        if (ext) begin
            if (code == SC_CTRL) key_mask[K_RCTRL] = 1'b1;
        end else begin
            case (code)
                SC_LSHIFT:   key_mask[K_LSHIFT]   = 1'b1;
                SC_RSHIFT:   key_mask[K_RSHIFT]   = 1'b1;
                SC_CTRL:     key_mask[K_LCTRL]    = 1'b1;
                SC_KP_PLUS:  key_mask[K_KP_PLUS]  = 1'b1;
                SC_EQUALS:   key_mask[K_EQUALS]   = 1'b1;
                SC_KP_MINUS: key_mask[K_KP_MINUS] = 1'b1;
                SC_DASH:     key_mask[K_DASH]     = 1'b1;
                SC_F12:      key_mask[K_F12]      = 1'b1;
                SC_F1:       key_mask[K_F1]       = 1'b1;
                SC_F2:       key_mask[K_F1+1]     = 1'b1;
                SC_F3:       key_mask[K_F1+2]     = 1'b1;
                SC_F4:       key_mask[K_F4]       = 1'b1;
                default: begin
                    for (int i = 0; i < 8; i++) begin
                        if (code == DIGIT_CODES[i])
                            key_mask[K_D1+i] = 1'b1;
                    end
                end
            endcase
        end
    endfunction

endpackage

// File: rtl/jtframe_debug_keys.sv
// PS/2 set-2 byte stream to held debug key levels (make/break, E0, E1).
// Ports: clk, rst_n, ps2_valid/ps2_code in, flush in; key levels out.
import jtframe_debug_keys_pkg::*;

module jtframe_debug_keys #(
    parameter int TOW = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_valid,
    input  logic [7:0] ps2_code,
    input  logic       flush,
    output logic       shift,
    output logic       ctrl,
    output logic       debug_plus,
    output logic       debug_minus,
    output logic       debug_rst,
    output logic [3:0] key_gfx,
    output logic [7:0] key_digit
);

    state_e           state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic [TOW-1:0]   tmo_q, tmo_d;
    logic [NKEYS-1:0] keys_q, keys_d;

    logic             make_en;
    logic             brk_en;
    logic             ext_sel;
    logic             byte_en;
    logic             tmo_hit;

    // A flush swallows any byte strobed in the same cycle
    assign byte_en = ps2_valid && !flush;
    assign tmo_hit = (state_q != IDLE) && (tmo_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (flush) begin
            state_d = IDLE;
            skip_d  = '0;
        end else if (ps2_valid) begin
            unique case (state_q)
                IDLE: begin
                    unique case (1'b1)
                        (ps2_code == SC_E0): state_d = EXT;
                        (ps2_code == SC_F0): state_d = BRK;
                        (ps2_code == SC_E1): begin
                            state_d = PAUSE;
                            skip_d  = PAUSE_SKIP;
                        end
                        default: state_d = IDLE;
                    endcase
                end
                EXT: begin
                    unique case (1'b1)
                        (ps2_code == SC_F0): state_d = EXTBRK;
                        (ps2_code == SC_E0): state_d = EXT;
                        default:             state_d = IDLE;
                    endcase
                end
                BRK, EXTBRK: state_d = IDLE;
                PAUSE: begin
                    if (skip_q <= 3'd1) begin
                        state_d = IDLE;
                        skip_d  = '0;
                    end else begin
                        skip_d  = skip_q - 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (tmo_hit) begin
            // Stale prefix: abandon the sequence, keep key levels
            state_d = IDLE;
            skip_d  = '0;
        end
    end

    // Idle-time counter; only runs while a sequence is pending
    always_comb begin
        tmo_d = tmo_q;
        if (ps2_valid || flush || state_q == IDLE)
            tmo_d = '0;
        else if (tmo_q != '1)
            tmo_d = tmo_q + 1'b1;
    end

    always_comb begin
        make_en = 1'b0;
        brk_en  = 1'b0;
        ext_sel = 1'b0;
        if (byte_en) begin
            unique case (state_q)
                IDLE: begin
                    make_en = (ps2_code != SC_E0) &&
                              (ps2_code != SC_F0) &&
                              (ps2_code != SC_E1) &&
                              !is_ignored(ps2_code);
                end
                EXT: begin
                    make_en = (ps2_code != SC_F0) &&
                              (ps2_code != SC_E0);
                    ext_sel = 1'b1;
                end
                BRK: brk_en = 1'b1;
                EXTBRK: begin
                    brk_en  = 1'b1;
                    ext_sel = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Repeated makes OR in an already-set bit, so typematic
    // repeat never drops a level
    always_comb begin
        logic [NKEYS-1:0] mask;
        mask   = key_mask(ps2_code, ext_sel);
        keys_d = keys_q;
        if (flush)
            keys_d = '0;
        else if (make_en)
            keys_d = keys_q | mask;
        else if (brk_en)
            keys_d = keys_q & ~mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            keys_q <= '0;
        else
            keys_q <= keys_d;
    end

    assign shift       = keys_q[K_LSHIFT] | keys_q[K_RSHIFT];
    assign ctrl        = keys_q[K_LCTRL]  | keys_q[K_RCTRL];
    assign debug_plus  = keys_q[K_KP_PLUS]  | keys_q[K_EQUALS];
    assign debug_minus = keys_q[K_KP_MINUS] | keys_q[K_DASH];
    assign debug_rst   = keys_q[K_F12];
    assign key_gfx     = keys_q[K_F4:K_F1];
    assign key_digit   = keys_q[K_D8:K_D1];

endmodule

// File: tb/tb_jtframe_debug_keys.sv
// Directed bench for jtframe_debug_keys: vector table plus
// hand sequences for timeout, reset, flush and typematic repeat.
module tb_jtframe_debug_keys;

    localparam int TOW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_valid = 1'b0;
    logic [7:0] ps2_code = 8'h00;
    logic       flush = 1'b0;
    logic       shift, ctrl, debug_plus, debug_minus, debug_rst;
    logic [3:0] key_gfx;
    logic [7:0] key_digit;

    int n_cmp = 0;
    int n_bad = 0;

    jtframe_debug_keys #(.TOW(TOW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_valid   (ps2_valid),
        .ps2_code    (ps2_code),
        .flush       (flush),
        .shift       (shift),
        .ctrl        (ctrl),
        .debug_plus  (debug_plus),
        .debug_minus (debug_minus),
        .debug_rst   (debug_rst),
        .key_gfx     (key_gfx),
        .key_digit   (key_digit)
    );

    always #5 clk = ~clk;

    // {shift, ctrl, plus, minus, rst, gfx[3:0], digit[7:0]}
    typedef struct {
        logic        v;
        logic        f;
        logic [7:0]  code;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [16:0] outs();
        return {shift, ctrl, debug_plus, debug_minus, debug_rst,
                key_gfx, key_digit};
    endfunction

    function automatic logic [16:0] e(
        input logic s, input logic c, input logic p,
        input logic m, input logic r,
        input logic [3:0] g, input logic [7:0] d
    );
        return {s, c, p, m, r, g, d};
    endfunction

    function automatic void add(input logic f, input logic [7:0] code,
                                input logic [16:0] x);
        vec_t t;
        t.v = 1'b1;
        t.f = f;
        t.code = code;
        t.exp = x;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [16:0] x);
        logic [16:0] got;
        got = outs();
        n_cmp++;
        if (got !== x) begin
            n_bad++;
            $display("FAIL %s: got %05h want %05h", name, got, x);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] c,
                        input logic f);
        ps2_valid = v;
        ps2_code  = c;
        flush     = f;
        @(posedge clk);
        #1;
        ps2_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    localparam logic [16:0] Z = 17'h0;

    initial begin
        // shift make/break, two-sided hold
        add(0, 8'h12, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'hF0, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'h12, Z);
        add(0, 8'h12, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'h59, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'hF0, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'h12, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'hF0, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'h59, Z);
        // ctrl: right via E0, left plain
        add(0, 8'hE0, Z);
        add(0, 8'h14, e(0,1,0,0,0,4'h0,8'h00));
        add(0, 8'h14, e(0,1,0,0,0,4'h0,8'h00));
        add(0, 8'hE0, e(0,1,0,0,0,4'h0,8'h00));
        add(0, 8'hF0, e(0,1,0,0,0,4'h0,8'h00));
        add(0, 8'h14, e(0,1,0,0,0,4'h0,8'h00));
        add(0, 8'hF0, e(0,1,0,0,0,4'h0,8'h00));
        add(0, 8'h14, Z);
        // extended codes other than 14 are ignored
        add(0, 8'hE0, Z);
        add(0, 8'h12, Z);
        add(0, 8'hE0, Z);
        add(0, 8'h59, Z);
        add(0, 8'hE0, Z);
        add(0, 8'h7B, Z);
        add(0, 8'h12, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'hE0, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'hF0, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'h12, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'hF0, e(1,0,0,0,0,4'h0,8'h00));
        add(0, 8'h12, Z);
        // digits
        add(0, 8'h16, e(0,0,0,0,0,4'h0,8'h01));
        add(0, 8'h3E, e(0,0,0,0,0,4'h0,8'h81));
        add(0, 8'hF0, e(0,0,0,0,0,4'h0,8'h81));
        add(0, 8'h16, e(0,0,0,0,0,4'h0,8'h80));
        add(0, 8'h1E, e(0,0,0,0,0,4'h0,8'h82));
        add(0, 8'h26, e(0,0,0,0,0,4'h0,8'h86));
        add(0, 8'h25, e(0,0,0,0,0,4'h0,8'h8E));
        add(0, 8'h2E, e(0,0,0,0,0,4'h0,8'h9E));
        add(0, 8'h36, e(0,0,0,0,0,4'h0,8'hBE));
        add(0, 8'h3D, e(0,0,0,0,0,4'h0,8'hFE));
        add(0, 8'h16, e(0,0,0,0,0,4'h0,8'hFF));
        // gfx and F12
        add(0, 8'h05, e(0,0,0,0,0,4'h1,8'hFF));
        add(0, 8'h0C, e(0,0,0,0,0,4'h9,8'hFF));
        add(0, 8'h07, e(0,0,0,0,1,4'h9,8'hFF));
        add(0, 8'h06, e(0,0,0,0,1,4'hB,8'hFF));
        add(0, 8'h04, e(0,0,0,0,1,4'hF,8'hFF));
        add(0, 8'hF0, e(0,0,0,0,1,4'hF,8'hFF));
        add(0, 8'h06, e(0,0,0,0,1,4'hD,8'hFF));
        // minus from two sources, protocol and unmapped bytes
        add(0, 8'h7B, e(0,0,0,1,1,4'hD,8'hFF));
        add(0, 8'h4E, e(0,0,0,1,1,4'hD,8'hFF));
        add(0, 8'hF0, e(0,0,0,1,1,4'hD,8'hFF));
        add(0, 8'h7B, e(0,0,0,1,1,4'hD,8'hFF));
        add(0, 8'hAA, e(0,0,0,1,1,4'hD,8'hFF));
        add(0, 8'hFA, e(0,0,0,1,1,4'hD,8'hFF));
        add(0, 8'h00, e(0,0,0,1,1,4'hD,8'hFF));
        add(0, 8'h1C, e(0,0,0,1,1,4'hD,8'hFF));
        // flush beats a same-cycle strobe
        add(1, 8'h7B, Z);
        // Pause sequence swallowed, then a real key
        add(0, 8'hE1, Z);
        add(0, 8'h14, Z);
        add(0, 8'h77, Z);
        add(0, 8'hE1, Z);
        add(0, 8'hF0, Z);
        add(0, 8'h14, Z);
        add(0, 8'hF0, Z);
        add(0, 8'h77, Z);
        add(0, 8'h79, e(0,0,1,0,0,4'h0,8'h00));
        add(0, 8'h55, e(0,0,1,0,0,4'h0,8'h00));
        add(0, 8'hF0, e(0,0,1,0,0,4'h0,8'h00));
        add(0, 8'h79, e(0,0,1,0,0,4'h0,8'h00));
        add(0, 8'hF0, e(0,0,1,0,0,4'h0,8'h00));
        add(0, 8'h55, Z);

        #2;
        idle(3);
        check("reset", Z);
        rst_n = 1'b1;
        idle(2);
        check("post_reset", Z);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].code, vecs[i].f);
            check($sformatf("vec%0d_%02h", i, vecs[i].code),
                  vecs[i].exp);
        end

        // Timeout drops a pending F0; key level survives it
        step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        idle(1 << TOW);
        check("tmo_hold", e(1,0,0,0,0,4'h0,8'h00));
        step(1'b1, 8'h12, 1'b0);
        check("tmo_make", e(1,0,0,0,0,4'h0,8'h00));
        // Just short of the timeout the break still applies
        step(1'b1, 8'hF0, 1'b0);
        idle((1 << TOW) - 2);
        step(1'b1, 8'h12, 1'b0);
        check("tmo_early", Z);

        // Flush discards a same-cycle F0
        step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'hF0, 1'b1);
        check("flush_f0", Z);
        step(1'b1, 8'h12, 1'b0);
        check("flush_next", e(1,0,0,0,0,4'h0,8'h00));

        // Reset mid-sequence
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("async_rst", Z);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        step(1'b1, 8'h12, 1'b0);
        check("rst_then_make", e(1,0,0,0,0,4'h0,8'h00));
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h12, 1'b0);

        // Back-to-back typematic repeat
        ps2_valid = 1'b1;
        ps2_code  = 8'h79;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rep%0d", i), e(0,0,1,0,0,4'h0,8'h00));
        end
        ps2_valid = 1'b0;
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h79, 1'b0);
        check("rep_release", Z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
